// File: rtl/divider_for_counter.sv
// rtl/divider_for_counter.sv - clock-enable generator dividing CLK by a fixed ratio
//
// Purpose:
//   Produces a one-CLK-wide enable pulse every DIVISOR clock cycles for the
//   seven-segment counter path. CEOUT is a synchronous count enable, never a
//   clock.
//
// Parameters:
//   DIVISOR  cycles between successive CEOUT pulses (1 .. 2^32-1)
//   CNT_W    derived counter width, not meant to be overridden
//
// Ports:
//   CLK    in   system clock, rising edge active
//   RST    in   asynchronous active-low reset
//   CEOUT  out  registered single-cycle enable pulse

module divider_for_counter #(
  parameter int unsigned DIVISOR = 40_000_000,
  parameter int unsigned CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1
) (
  input  logic CLK,
  input  logic RST,
  output logic CEOUT
);

  // A zero ratio has no meaning; stop elaboration rather than build a
  // counter that can never reach its terminal value.
  generate
    if (DIVISOR == 0) begin : g_bad_divisor
      $error("divider_for_counter: DIVISOR must be at least 1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] cnt;

  // The terminal compare keeps cnt within 0..DIVISOR-1, so the CNT_W-bit
  // increment can never wrap on its own. With DIVISOR = 1 the compare is
  // always true and CEOUT stays high while out of reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt   <= '0;
      CEOUT <= 1'b0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      CEOUT <= 1'b1;
    end else begin
      cnt   <= cnt + 1'b1;
      CEOUT <= 1'b0;
    end
  end

endmodule

// File: tb/tb_divider_for_counter.sv
// tb/tb_divider_for_counter.sv - self-checking bench for divider_for_counter
`timescale 1ns/1ps

module tb_divider_for_counter;

  logic clk = 1'b0;
  always #12.5 clk = ~clk;

  logic rst4 = 1'b0, rst1 = 1'b0, rst5 = 1'b0, rstd = 1'b0;
  logic ce4, ce1, ce5, ced;

  divider_for_counter #(.DIVISOR(4)) dut4 (.CLK(clk), .RST(rst4), .CEOUT(ce4));
  divider_for_counter #(.DIVISOR(1)) dut1 (.CLK(clk), .RST(rst1), .CEOUT(ce1));
  divider_for_counter #(.DIVISOR(5)) dut5 (.CLK(clk), .RST(rst5), .CEOUT(ce5));
  divider_for_counter                dutd (.CLK(clk), .RST(rstd), .CEOUT(ced));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Sample point: 2 ns after a rising edge, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    int   edge_n;
    logic exp_ce;
    int   exp_cnt;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int pulses;
    int last_edge;
    int edge_n;
    logic prev_ce;
    logic found;
    longint k5;
    longint kd;
    logic exp_ce;

    // Expected behaviour for DIVISOR = 4 after reset release: pulse after
    // every fourth edge, counter equals edges modulo 4.
    for (int i = 0; i < 9; i++) begin
      tbl[i].edge_n  = i + 1;
      tbl[i].exp_ce  = ((i + 1) % 4 == 0);
      tbl[i].exp_cnt = (i + 1) % 4;
    end

    // Reset hold
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_ce4", 64'(ce4), 64'd0);
      check("hold_cnt4", 64'(dut4.cnt), 64'd0);
      check("hold_ce1", 64'(ce1), 64'd0);
    end
    check("default_cnt_w", 64'(dutd.CNT_W), 64'd26);

    // First pulse and counter trajectory
    rst4 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("first_ce_e%0d", tbl[i].edge_n), 64'(ce4), 64'(tbl[i].exp_ce));
      check($sformatf("first_cnt_e%0d", tbl[i].edge_n), 64'(dut4.cnt), 64'(tbl[i].exp_cnt));
    end

    // Periodicity: edges 10..49 contain pulses at 12,16,...,48
    pulses = 0;
    last_edge = 8;
    prev_ce = ce4;
    for (int e = 10; e < 50; e++) begin
      tick();
      if (ce4) begin
        pulses++;
        check("period_spacing", 64'(e - last_edge), 64'd4);
        last_edge = e;
        check("period_width", 64'(prev_ce), 64'd0);
      end
      prev_ce = ce4;
    end
    check("period_count", 64'(pulses), 64'd10);

    // Asynchronous reset while CEOUT is high
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (ce4) found = 1'b1;
    end
    check("midpulse_found", 64'(found), 64'd1);
    #5 rst4 = 1'b0;
    #1;
    check("async_ce_drop", 64'(ce4), 64'd0);
    check("async_cnt_clear", 64'(dut4.cnt), 64'd0);
    tick();
    check("async_hold_ce", 64'(ce4), 64'd0);
    rst4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("restart_ce_e%0d", tbl[i].edge_n), 64'(ce4), 64'(tbl[i].exp_ce));
    end

    // Degenerate ratio
    rst1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("div1_ce_e%0d", i + 1), 64'(ce1), 64'd1);
      check("div1_cnt", 64'(dut1.cnt), 64'd0);
    end

    // Random reset pulses on DIVISOR = 5 against an edge-count model;
    // default-ratio instance free-runs alongside.
    k5 = 0;
    kd = 0;
    rst5 = 1'b1;
    rstd = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (rst5) k5++;
      else k5 = 0;
      kd++;
      exp_ce = (k5 != 0) && (k5 % 5 == 0);
      check("rand_ce5", 64'(ce5), 64'(exp_ce));
      check("rand_cnt5", 64'(dut5.cnt), 64'(k5 % 5));
      check("dflt_ce", 64'(ced), 64'((kd % 40_000_000) == 0));
      check("dflt_cnt", 64'(dutd.cnt), 64'(kd % 40_000_000));
      if (rst5 && $urandom_range(0, 39) == 0) begin
        rst5 = 1'b0;
        #1;
        check("rand_async_ce5", 64'(ce5), 64'd0);
        check("rand_async_cnt5", 64'(dut5.cnt), 64'd0);
      end else if (!rst5 && $urandom_range(0, 2) == 0) begin
        rst5 = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so the run can never hang.
  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
